// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a preloadable 64-bit word array (FIXED/INCR/WRAP bursts).
// Define AXI_RESP_BUBBLE_EN to insert a one-cycle rvalid gap after every non-last beat.

module axi_read_responder #(
  parameter int          MEM_WORDS    = 4096,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter int          READ_LATENCY = 2,
  localparam int         AW           = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m_axi_arvalid,
  input  logic [63:0]   m_axi_araddr,
  input  logic [7:0]    m_axi_arlen,
  input  logic [2:0]    m_axi_arsize,
  input  logic [1:0]    m_axi_arburst,
  output logic          m_axi_arready,
  output logic          m_axi_rvalid,
  output logic [63:0]   m_axi_rdata,
  output logic [1:0]    m_axi_rresp,
  output logic          m_axi_rlast,
  input  logic          m_axi_rready,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [63:0]   mem_wdata
);

`ifdef AXI_RESP_BUBBLE_EN
  localparam bit BUBBLE = 1'b1;
`else
  localparam bit BUBBLE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t      state_q;
  logic        arready_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [63:0] addr_q;
  logic [7:0]  len_q;
  logic [1:0]  burst_q;
  logic        slverr_q;
  logic [7:0]  beat_cnt_q;
  logic [7:0]  lat_q;
  logic [63:0] mem_q [MEM_WORDS];

  logic [63:0] addr_d;
  logic [63:0] rdata_d;
  logic [1:0]  rresp_d;
  logic [63:0] off_s;
  logic [63:0] word_s;
  logic        dec_err_s;
  logic        load_s;

  // Address of the beat after 'a'; WRAP windows are (len+1)*8 bytes, so the mask is {len,3'b111}.
  function automatic logic [63:0] next_addr(input logic [63:0] a, input logic [7:0] len,
                                            input logic [1:0] burst);
    logic [63:0] mask;
    mask = {53'd0, len, 3'b111};
    case (burst)
      2'b00:   next_addr = a;
      2'b10:   next_addr = (a & ~mask) | ((a + 64'd8) & mask);
      default: next_addr = a + 64'd8;
    endcase
  endfunction

  function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    burst_err   = (size != 3'd3) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
  endfunction

  // Decode the pending beat address and decide whether a beat is loaded this cycle.
  always_comb begin
    off_s     = addr_q - BASE_ADDR;
    word_s    = off_s >> 3;
    dec_err_s = (addr_q < BASE_ADDR) || (word_s >= 64'(MEM_WORDS));
    addr_d    = next_addr(addr_q, len_q, burst_q);
    rdata_d   = 64'd0;
    rresp_d   = 2'b00;
    if (slverr_q) begin
      rresp_d = 2'b10;
    end else if (dec_err_s) begin
      rresp_d = 2'b11;
    end else begin
      rdata_d = mem_q[word_s[AW-1:0]];
    end
    // A beat loads when none is presented, or when the current non-last beat is taken.
    load_s = (state_q == S_BURST) &&
             (!rvalid_q || (m_axi_rready && !rlast_q && !BUBBLE));
  end

  // Preload port; the array has no reset so contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Request/response FSM with all AXI outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rdata_q    <= 64'd0;
      rresp_q    <= 2'b00;
      addr_q     <= 64'd0;
      len_q      <= 8'd0;
      burst_q    <= 2'b00;
      slverr_q   <= 1'b0;
      beat_cnt_q <= 8'd0;
      lat_q      <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (m_axi_arvalid && arready_q) begin
            addr_q     <= m_axi_araddr & ~64'h7;
            len_q      <= m_axi_arlen;
            burst_q    <= m_axi_arburst;
            slverr_q   <= burst_err(m_axi_arsize, m_axi_arburst, m_axi_arlen);
            beat_cnt_q <= 8'd0;
            arready_q  <= 1'b0;
            if (READ_LATENCY > 0) begin
              state_q <= S_WAIT;
              lat_q   <= 8'(READ_LATENCY);
            end else begin
              state_q <= S_BURST;
              lat_q   <= 8'd0;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          arready_q <= 1'b0;
          if (lat_q <= 8'd1) begin
            state_q <= S_BURST;
            lat_q   <= 8'd0;
          end else begin
            lat_q <= lat_q - 8'd1;
          end
        end
        S_BURST: begin
          arready_q <= 1'b0;
          if (load_s) begin
            rvalid_q   <= 1'b1;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            rlast_q    <= (beat_cnt_q == len_q);
            beat_cnt_q <= beat_cnt_q + 8'd1;
            addr_q     <= addr_d;
          end else if (rvalid_q && m_axi_rready) begin
            // Either the final beat completed, or a bubble follows a non-last beat.
            rvalid_q <= 1'b0;
            if (rlast_q) begin
              rlast_q   <= 1'b0;
              state_q   <= S_IDLE;
              arready_q <= 1'b1;
            end else begin
              rlast_q <= 1'b0;
            end
          end else begin
            rvalid_q <= rvalid_q;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b0;
          rlast_q   <= 1'b0;
        end
      endcase
    end
  end

  assign m_axi_arready = arready_q;
  assign m_axi_rvalid  = rvalid_q;
  assign m_axi_rdata   = rdata_q;
  assign m_axi_rresp   = rresp_q;
  assign m_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Scoreboard bench for axi_read_responder: expected beats are queued when AR is driven
// and compared against the R channel on every falling edge.

module tb_axi_read_responder;

  localparam int          MEM_WORDS = 4096;
  localparam logic [63:0] BASE      = 64'h0000_0000_8000_0000;
  localparam int          LAT       = 2;
  localparam int          AW        = $clog2(MEM_WORDS);
`ifdef AXI_RESP_BUBBLE_EN
  localparam bit BUB = 1'b1;
`else
  localparam bit BUB = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          m_axi_arvalid;
  logic [63:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arready;
  logic          m_axi_rvalid;
  logic [63:0]   m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [63:0]   mem_wdata;

  typedef struct packed {
    logic        last;
    logic [1:0]  resp;
    logic [63:0] data;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       popped;
  int          hold_log[$];
  int          hold_cnt;
  bit          rr_pat[$];
  logic [63:0] model_mem [MEM_WORDS];
  int          n_checks;
  int          n_errors;

  axi_read_responder #(
    .MEM_WORDS   (MEM_WORDS),
    .BASE_ADDR   (BASE),
    .READ_LATENCY(LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_axi_arvalid(m_axi_arvalid),
    .m_axi_araddr (m_axi_araddr),
    .m_axi_arlen  (m_axi_arlen),
    .m_axi_arsize (m_axi_arsize),
    .m_axi_arburst(m_axi_arburst),
    .m_axi_arready(m_axi_arready),
    .m_axi_rvalid (m_axi_rvalid),
    .m_axi_rdata  (m_axi_rdata),
    .m_axi_rresp  (m_axi_rresp),
    .m_axi_rlast  (m_axi_rlast),
    .m_axi_rready (m_axi_rready),
    .mem_we       (mem_we),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Reference beats: WRAP addresses are computed as an offset modulo the window size.
  task automatic push_burst(input logic [63:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] a0, a, wb, wbase;
    bit          slv;
    beat_t       b;
    a0    = addr & ~64'h7;
    slv   = (size != 3'd3) || (burst == 2'b11) ||
            ((burst == 2'b10) && !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
    wb    = (64'(len) + 64'd1) * 64'd8;
    wbase = a0 - (a0 % wb);
    for (int i = 0; i <= int'(len); i++) begin
      case (burst)
        2'b00:   a = a0;
        2'b10:   a = wbase + ((a0 - wbase + 64'(i) * 64'd8) % wb);
        default: a = a0 + 64'(i) * 64'd8;
      endcase
      b.last = (i == int'(len));
      b.resp = 2'b00;
      b.data = 64'd0;
      if (slv) b.resp = 2'b10;
      else if ((a < BASE) || (((a - BASE) >> 3) >= 64'(MEM_WORDS))) b.resp = 2'b11;
      else b.data = model_mem[int'((a - BASE) >> 3)];
      exp_q.push_back(b);
    end
  endtask

  task automatic preload(input int idx, input logic [63:0] d);
    @(posedge clk); #1;
    mem_we    = 1'b1;
    mem_waddr = AW'(idx);
    mem_wdata = d;
    @(posedge clk); #1;
    mem_we = 1'b0;
    model_mem[idx] = d;
  endtask

  // Issue one AR and verify the first-beat latency relative to the handshake edge.
  task automatic do_ar(input logic [63:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int waited;
    push_burst(addr, len, size, burst);
    @(posedge clk); #1;
    m_axi_arvalid = 1'b1;
    m_axi_araddr  = addr;
    m_axi_arlen   = len;
    m_axi_arsize  = size;
    m_axi_arburst = burst;
    waited = 0;
    @(negedge clk);
    while (!m_axi_arready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_val("arready_wait", m_axi_arready, 1'b1);
    @(posedge clk); #1;
    m_axi_arvalid = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      @(negedge clk);
      check_val("first_rvalid", m_axi_rvalid, (k == LAT + 1));
      check_val("arready_busy", m_axi_arready, 1'b0);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("burst_done", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clk);
    check_val("arready_after", m_axi_arready, 1'b1);
    check_val("rvalid_after", m_axi_rvalid, 1'b0);
  endtask

  // rready driver: consumes a pattern only while a beat is presented, otherwise ready.
  initial begin
    m_axi_rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (m_axi_rvalid && rr_pat.size() > 0) m_axi_rready = rr_pat.pop_front();
      else m_axi_rready = 1'b1;
    end
  end

  // R-channel monitor: every presented beat (stalled or not) must match the queue head.
  initial begin
    hold_cnt = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (m_axi_rvalid) begin
          if (exp_q.size() == 0) begin
            check_val("unexpected_beat", m_axi_rvalid, 1'b0);
          end else begin
            check_val("rdata", m_axi_rdata, exp_q[0].data);
            check_val("rresp", m_axi_rresp, exp_q[0].resp);
            check_val("rlast", m_axi_rlast, exp_q[0].last);
            if (m_axi_rready) begin
              popped = exp_q.pop_front();
              hold_log.push_back(hold_cnt + 1);
              hold_cnt = 0;
            end else begin
              hold_cnt++;
            end
          end
        end else begin
          check_val("rlast_idle", m_axi_rlast, 1'b0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", n_checks);
    $fatal(1);
  end

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = 64'd0;
    m_axi_arlen   = 8'd0;
    m_axi_arsize  = 3'd3;
    m_axi_arburst = 2'b01;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = 64'd0;

    repeat (2) @(negedge clk);
    check_val("rst_arready", m_axi_arready, 1'b0);
    check_val("rst_rvalid", m_axi_rvalid, 1'b0);
    check_val("rst_rlast", m_axi_rlast, 1'b0);
    check_val("rst_rdata", m_axi_rdata, 64'd0);
    check_val("rst_rresp", m_axi_rresp, 2'b00);
    reset = 1'b0;
    #1 check_val("arready_before_edge", m_axi_arready, 1'b0);
    @(negedge clk);
    check_val("arready_post_reset", m_axi_arready, 1'b1);

    for (int i = 0; i < 8; i++) preload(i, 64'h1000 + 64'(i));
    preload(MEM_WORDS - 1, 64'hCAFE_0000_0000_0FFF);

    // INCR 8 beats, streaming
    hold_log.delete();
    do_ar(BASE, 8'd7, 3'd3, 2'b01);
    wait_done();
    check_val("incr_beats", hold_log.size(), 8);

    // Backpressure 1,0,0,1,1 with a preload write to the stalled word
    hold_log.delete();
    rr_pat.push_back(1'b1); rr_pat.push_back(1'b0); rr_pat.push_back(1'b0);
    rr_pat.push_back(1'b1); rr_pat.push_back(1'b1);
    do_ar(BASE, 8'd7, 3'd3, 2'b01);
    @(posedge clk); #1;
    mem_we = 1'b1; mem_waddr = AW'(1); mem_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(posedge clk); #1;
    mem_we = 1'b0;
    wait_done();
    check_val("bp_beats", hold_log.size(), 8);
    check_val("bp_hold_beat2", hold_log[1], 3);
    preload(1, 64'h1001);

    // WRAP, decode errors, slave errors, FIXED, unaligned INCR
    do_ar(BASE + 64'h18, 8'd3, 3'd3, 2'b10);
    wait_done();
    do_ar(BASE + 64'((MEM_WORDS - 1) * 8), 8'd1, 3'd3, 2'b01);
    wait_done();
    do_ar(BASE - 64'd8, 8'd0, 3'd3, 2'b01);
    wait_done();
    do_ar(BASE, 8'd2, 3'd2, 2'b01);
    wait_done();
    do_ar(BASE + 64'd8, 8'd1, 3'd3, 2'b11);
    wait_done();
    do_ar(BASE, 8'd2, 3'd3, 2'b10);
    wait_done();
    do_ar(BASE + 64'd16, 8'd2, 3'd3, 2'b00);
    wait_done();
    do_ar(BASE + 64'h23, 8'd1, 3'd3, 2'b01);
    wait_done();

    // rvalid shape of a 4-beat burst: gaps only when the bubble option is built in
    do_ar(BASE, 8'd3, 3'd3, 2'b01);
    for (int j = 1; j <= (BUB ? 6 : 3); j++) begin
      @(negedge clk);
      check_val("rvalid_pattern", m_axi_rvalid, BUB ? ((j % 2) == 0) : 1'b1);
    end
    wait_done();

    // Reset in the middle of an 8-beat burst
    do_ar(BASE, 8'd7, 3'd3, 2'b01);
    n = 0;
    while (exp_q.size() > 6 && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    check_val("mid_reached", exp_q.size(), 6);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_val("midrst_rvalid", m_axi_rvalid, 1'b0);
    check_val("midrst_arready", m_axi_arready, 1'b0);
    check_val("midrst_rlast", m_axi_rlast, 1'b0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 check_val("midrst_arready_low", m_axi_arready, 1'b0);
    @(negedge clk);
    check_val("midrst_arready_up", m_axi_arready, 1'b1);
    do_ar(BASE + 64'd48, 8'd0, 3'd3, 2'b01);
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
